// File: rtl/rom_dl_loader.sv
// HPS ioctl download to ROM write-port bridge: one-byte buffer with ioctl_wait backpressure,
// load statistics (count, checksum, error) and a core reset hold that releases after a settle time.
module rom_dl_loader #(
  parameter int          ADDR_W      = 14,
  parameter int          ROM_BYTES   = 16384,
  parameter int          HOLD_CYCLES = 16,
  parameter logic [7:0]  DL_INDEX    = 8'd0
) (
  input  logic              clk_sys,
  input  logic              nRESET,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  input  logic              dn_ready,
  output logic              core_reset,
  output logic              load_ok,
  output logic              load_err,
  output logic [ADDR_W:0]   byte_count,
  output logic [7:0]        checksum,
  output logic [2:0]        o_dbg_state
);

  // Handshake: dn_wr rises with a buffered byte and holds dn_addr/dn_data stable until a rising
  // clk_sys edge samples dn_ready high; ioctl_wait mirrors dn_wr so hps_io stalls meanwhile.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PEND = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int                CNT_W        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LP_HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [24:0]       LP_LIMIT     = 25'(ROM_BYTES);
  localparam logic [ADDR_W:0]   LP_FULL      = (ADDR_W + 1)'(ROM_BYTES);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic              r_wait;
  logic              r_dn_wr;
  logic [ADDR_W-1:0] r_dn_addr;
  logic [7:0]        r_dn_data;
  logic              r_core_reset;
  logic              r_load_ok;
  logic              r_load_err;
  logic [ADDR_W:0]   r_byte_count;
  logic [7:0]        r_checksum;

  logic w_sel;
  logic w_in_range;

  assign w_sel      = ioctl_download && (ioctl_index == DL_INDEX);
  assign w_in_range = ioctl_addr < LP_LIMIT;

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      r_state      <= ST_IDLE;
      r_hold_cnt   <= '0;
      r_wait       <= 1'b0;
      r_dn_wr      <= 1'b0;
      r_dn_addr    <= '0;
      r_dn_data    <= '0;
      r_core_reset <= 1'b1;
      r_load_ok    <= 1'b0;
      r_load_err   <= 1'b0;
      r_byte_count <= '0;
      r_checksum   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_sel) begin
            r_state      <= ST_LOAD;
            r_byte_count <= '0;
            r_checksum   <= '0;
            r_load_err   <= 1'b0;
            r_load_ok    <= 1'b0;
            r_core_reset <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (!w_sel) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= LP_HOLD_INIT;
          end else if (ioctl_wr) begin
            if (w_in_range) begin
              r_dn_addr    <= ioctl_addr[ADDR_W-1:0];
              r_dn_data    <= ioctl_dout;
              r_dn_wr      <= 1'b1;
              r_wait       <= 1'b1;
              r_checksum   <= r_checksum + ioctl_dout;
              r_state      <= ST_PEND;
              if (!(&r_byte_count)) r_byte_count <= r_byte_count + 1'b1;
            end else begin
              r_load_err <= 1'b1;
            end
          end
        end
        ST_PEND: begin
          // A strobe here means hps_io ignored ioctl_wait; the byte cannot be buffered.
          if (w_sel && ioctl_wr) r_load_err <= 1'b1;
          if (dn_ready) begin
            r_dn_wr <= 1'b0;
            r_wait  <= 1'b0;
            if (w_sel) begin
              r_state <= ST_LOAD;
            end else begin
              r_state    <= ST_HOLD;
              r_hold_cnt <= LP_HOLD_INIT;
            end
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state      <= ST_DONE;
            r_core_reset <= 1'b0;
            r_load_ok    <= (r_byte_count == LP_FULL) && !r_load_err;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ioctl_wait  = r_wait;
  assign dn_addr     = r_dn_addr;
  assign dn_data     = r_dn_data;
  assign dn_wr       = r_dn_wr;
  assign core_reset  = r_core_reset;
  assign load_ok     = r_load_ok;
  assign load_err    = r_load_err;
  assign byte_count  = r_byte_count;
  assign checksum    = r_checksum;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rom_dl_loader.sv
// Self-checking bench for rom_dl_loader: randomized ROM-side readiness and data against a
// queue-based model of accepted bytes, count, checksum, error and reset-hold timing.
module tb_rom_dl_loader;

  localparam int         ADDR_W      = 10;
  localparam int         ROM_BYTES   = 1024;
  localparam int         HOLD_CYCLES = 5;
  localparam logic [7:0] DL_INDEX    = 8'd0;

  logic              clk_sys = 1'b0;
  logic              nRESET;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic              dn_ready = 1'b0;
  logic              core_reset;
  logic              load_ok;
  logic              load_err;
  logic [ADDR_W:0]   byte_count;
  logic [7:0]        checksum;
  logic [2:0]        dbg_state;

  rom_dl_loader #(
    .ADDR_W(ADDR_W), .ROM_BYTES(ROM_BYTES), .HOLD_CYCLES(HOLD_CYCLES), .DL_INDEX(DL_INDEX)
  ) dut (
    .clk_sys(clk_sys), .nRESET(nRESET), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .dn_addr(dn_addr), .dn_data(dn_data),
    .dn_wr(dn_wr), .dn_ready(dn_ready), .core_reset(core_reset), .load_ok(load_ok),
    .load_err(load_err), .byte_count(byte_count), .checksum(checksum), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference model: bytes awaiting a ROM write, plus load statistics
  logic [ADDR_W+7:0] exp_q[$];
  int                m_count;
  logic [7:0]        m_sum;
  logic              m_err;
  int                n_accept;
  int                ready_mode = 0;
  int                stall_left = 0;
  int                wait_run = 0;
  int                max_wait_run = 0;

  // ROM side: choose dn_ready for the coming edge, then score any write it accepts
  always @(negedge clk_sys) begin
    if (stall_left > 0 && dn_wr) begin
      dn_ready = 1'b0;
      stall_left--;
    end else if (ready_mode == 0) begin
      dn_ready = ($urandom_range(0, 3) != 0);
    end else begin
      dn_ready = 1'b1;
    end
    if (ioctl_wait) begin
      wait_run++;
    end else if (wait_run != 0) begin
      if (wait_run > max_wait_run) max_wait_run = wait_run;
      wait_run = 0;
    end
    if (dn_wr) begin
      if (exp_q.size() == 0) begin
        check_eq("dn_wr_spurious", 32'(dn_wr), 32'd0);
      end else begin
        check_eq("dn_addr_data", 32'({dn_addr, dn_data}), 32'(exp_q[0]));
        if (dn_ready) begin
          void'(exp_q.pop_front());
          n_accept++;
        end
      end
    end
  end

  // driver tasks (all inputs change at the falling edge)
  task automatic wait_idle();
    int t = 0;
    while (ioctl_wait) begin
      @(negedge clk_sys);
      t++;
      if (t > 200) begin
        check_eq("wait_timeout", 32'(ioctl_wait), 32'd0);
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    wait_idle();
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (ioctl_download && ioctl_index == DL_INDEX) begin
      if (a < 25'(ROM_BYTES)) begin
        exp_q.push_back({a[ADDR_W-1:0], d});
        m_count++;
        m_sum += d;
      end else begin
        m_err = 1'b1;
      end
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_load(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    if (idx == DL_INDEX) begin
      m_count      = 0;
      m_sum        = 8'd0;
      m_err        = 1'b0;
      n_accept     = 0;
      max_wait_run = 0;
    end
    @(negedge clk_sys);
  endtask

  task automatic end_load(input string tag);
    int k = 0;
    wait_idle();
    ioctl_download = 1'b0;
    while (core_reset && k < 100) begin
      @(negedge clk_sys);
      k++;
    end
    check_eq({tag, "_hold"}, 32'(k), 32'(HOLD_CYCLES + 1));
    check_eq({tag, "_count"}, 32'(byte_count), 32'(m_count));
    check_eq({tag, "_sum"}, 32'(checksum), 32'(m_sum));
    check_eq({tag, "_err"}, 32'(load_err), 32'(m_err));
    check_eq({tag, "_ok"}, 32'(load_ok), 32'((m_count == ROM_BYTES) && !m_err));
    check_eq({tag, "_accepted"}, 32'(n_accept), 32'(m_count));
    check_eq({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
  endtask

  task automatic full_load(input string tag);
    start_load(DL_INDEX);
    for (int i = 0; i < ROM_BYTES; i++) send_byte(25'(i), 8'(i));
    end_load(tag);
  endtask

  initial begin
    logic [2:0] state_before;
    int         cnt_before;
    logic [7:0] sum_before;
    nRESET = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(negedge clk_sys);
    check_eq("rst_core_reset", 32'(core_reset), 32'd1);
    check_eq("rst_dn_wr", 32'(dn_wr), 32'd0);
    check_eq("rst_wait", 32'(ioctl_wait), 32'd0);
    check_eq("rst_dn_addr", 32'({dn_addr, dn_data}), 32'd0);
    check_eq("rst_stats", 32'({byte_count, checksum, load_ok, load_err}), 32'd0);
    nRESET = 1'b1;
    repeat (2) @(negedge clk_sys);
    check_eq("idle_core_reset", 32'(core_reset), 32'd1);

    // full image, ROM always ready
    ready_mode = 1;
    full_load("t1");
    check_eq("t1_sum_const", 32'(checksum), 32'h00);

    // another index is invisible
    state_before = dbg_state;
    cnt_before   = m_count;
    sum_before   = m_sum;
    start_load(8'd1);
    for (int i = 0; i < 10; i++) send_byte(25'($urandom_range(0, ROM_BYTES - 1)), 8'($urandom));
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_eq("t5_core_reset", 32'(core_reset), 32'd0);
    check_eq("t5_ok", 32'(load_ok), 32'd1);
    check_eq("t5_count", 32'(byte_count), 32'(cnt_before));
    check_eq("t5_sum", 32'(checksum), 32'(sum_before));
    check_eq("t5_wait", 32'(ioctl_wait), 32'd0);
    check_eq("t5_state", 32'(dbg_state), 32'(state_before));

    // ROM stalls three cycles on byte 5
    ready_mode = 1;
    start_load(DL_INDEX);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) stall_left = 3;
      send_byte(25'(i), 8'($urandom));
    end
    end_load("t2");
    check_eq("t2_wait_cycles", 32'(max_wait_run), 32'd4);

    // short load, random ROM readiness
    ready_mode = 0;
    start_load(DL_INDEX);
    for (int i = 0; i < 100; i++) send_byte(25'(i), 8'h01);
    end_load("t3");
    check_eq("t3_sum_const", 32'(checksum), 32'h64);

    // out-of-range address, then a strobe while a byte is pending
    start_load(DL_INDEX);
    send_byte(25'h400, 8'($urandom));
    check_eq("t4_oob_err", 32'(load_err), 32'd1);
    check_eq("t4_oob_count", 32'(byte_count), 32'd0);
    stall_left = 3;
    send_byte(25'd3, 8'($urandom));
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd7;
    ioctl_dout = 8'($urandom);
    m_err      = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    end_load("t4");

    // reset while a byte is pending, then a full load
    ready_mode = 1;
    start_load(DL_INDEX);
    stall_left = 100;
    send_byte(25'd2, 8'($urandom));
    check_eq("t6_pending", 32'(dn_wr), 32'd1);
    nRESET = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    nRESET = 1'b1;
    exp_q.delete();
    stall_left = 0;
    check_eq("t6_dn_wr", 32'(dn_wr), 32'd0);
    check_eq("t6_wait", 32'(ioctl_wait), 32'd0);
    check_eq("t6_counters", 32'({byte_count, checksum}), 32'd0);
    check_eq("t6_core_reset", 32'(core_reset), 32'd1);
    ready_mode = 0;
    full_load("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
